linebuf_page_sched: RTL and testbench
=====================================

Name: linebuf_page_sched

Overview:
Page scheduler for the paged dual-port line buffer used by the line-multiplier. It hands free pages to the line writer and ready pages to the line reader, in circular order. It generates the read-side page, address and enable, and repeats each stored line N times for line doubling, tripling and so on. On read underrun it re-reads the last held line.

Parameters:
num_of_pages, 4, number of line pages in the buffer RAM; must be >= 2
pagesize, 1024, words per page; matches the RAM pagesize
rpt_max, 4, maximum repeats per line; must be >= 1
Derived widths: PAGE_W = clog2(num_of_pages); ADDR_W = clog2(pagesize); LEN_W = clog2(pagesize+1); RPT_W = clog2(rpt_max+1)

Ports:
CLK  in  1  single clock; drives both RAM ports
RST  in  1  synchronous, active-high reset
wr_start  in  1  pulse; the writer wants to begin a new line
wr_done  in  1  pulse; the writer has finished the current line
wr_len  in  LEN_W  valid word count of the finished line; sampled with wr_done
wr_busy  out  1  a page is claimed for writing; the writer may assert the RAM wren only while this is high
wrpage  out  PAGE_W  page the writer must use
wr_drop  out  1  1-cycle pulse; wr_start was refused because no page was free
rd_start  in  1  pulse; start of one output line
rd_rpt  in  RPT_W  repeat count; sampled when a new page is acquired
rden  out  1  RAM read enable
rdpage  out  PAGE_W  RAM read page
rdaddr  out  ADDR_W  RAM read address
rd_line_done  out  1  1-cycle pulse after the last rden of a pass
rd_underrun  out  1  1-cycle pulse; no new ready page was available at rd_start

Behaviour:
- Page state per page: FREE, WRITING, READY or READING, plus a stored length per page. Write pointer wp and read pointer rp advance modulo num_of_pages.
- Reset: all pages FREE, wp = rp = 0, all stored lengths 0, both FSMs idle. Every output is 0 in the cycle after RST is high. Reset mid-line aborts immediately; rden is 0 in the next cycle.
- Write FSM has two states, W_IDLE and W_ACT.
  - W_IDLE + wr_start, page[wp] FREE: page becomes WRITING, wrpage <= wp, wr_busy = 1 from the next cycle.
  - W_IDLE + wr_start, page[wp] not FREE: wr_drop pulses in the next cycle; the FSM stays idle.
  - W_ACT + wr_done: len = min(wr_len, pagesize). If len > 0, the page becomes READY with that length, wp advances, and the FSM returns to W_IDLE with wr_busy = 0. If len == 0, the page returns to FREE and wp does not advance.
  - W_ACT + wr_start without wr_done: the current line is aborted and the same page is restarted; wr_busy stays 1.
  - W_ACT + wr_start together with wr_done: wr_done is processed, then wr_start is evaluated against the advanced wp, using page states as registered this cycle.
  - wr_done in W_IDLE is ignored.
- Read FSM has three states: R_IDLE (no page held), R_READ (streaming) and R_HOLD (page held between passes).
  - Repeat load: rep = rd_rpt, with 0 treated as 1 and values above rpt_max clamped to rpt_max.
  - R_IDLE + rd_start, page[rp] READY: page becomes READING, load rep, go to R_READ.
  - R_IDLE + rd_start, page[rp] not READY: rd_underrun pulses; stay in R_IDLE.
  - R_READ: starting the cycle after acceptance, rden = 1 for exactly len cycles. rdaddr runs 0..len-1; rdpage is constant. rd_line_done pulses on the cycle after the last rden. rep is decremented, then the FSM goes to R_HOLD.
  - R_HOLD + rd_start, rep > 0: re-read the held page.
  - R_HOLD + rd_start, rep == 0, page[rp+1] READY: in the same cycle, the held page becomes FREE, rp advances, the new page becomes READING, and rep is reloaded.
  - R_HOLD + rd_start, rep == 0, next page not READY: rd_underrun pulses and the held page is re-read; rep stays 0.
  - rd_start during R_READ is ignored.
- A page frees in the same cycle the writer checks it: the writer sees the page state as registered before that edge, so the free takes effect one cycle later.
- Writer and reader never share a page: the writer claims only FREE pages, and the reader only READY or held pages.

Optional Feature:
LINEBUF_PAGE_STATS_EN: when defined, adds two outputs, drop_cnt[7:0] and underrun_cnt[7:0]. They count wr_drop and rd_underrun pulses, saturate at 255, and clear on RST. When not defined, neither port exists and no counters are built.

Test Plan:
- Basic repeat: wr_start, then wr_done with wr_len = 640; rd_start with rd_rpt = 2. Expect rden for 640 cycles, rdpage = 0, rdaddr 0..639, then rd_line_done. A second rd_start re-reads page 0. A third rd_start with no new line gives rd_underrun plus a re-read of page 0.
- Overflow: write 4 lines of length 100 with num_of_pages = 4 and no reads. A 5th wr_start gives wr_drop = 1 and wr_busy stays 0. After one full read with rd_rpt = 1 followed by a next acquire, page 0 is FREE and the next wr_start gets wrpage = 0.
- Length edges: wr_len = 0 leaves the page FREE and wp unchanged; a following rd_start gives rd_underrun. wr_len = 2000 is stored as 1024; rdaddr ends at 1023.
- Repeat clamp: rd_rpt = 0 gives exactly 1 pass before the next page is taken; rd_rpt = 7 with rpt_max = 4 gives exactly 4 passes.
- Simultaneous and reset: wr_done and wr_start in the same cycle gives wrpage = wp+1 and wr_busy held at 1. RST asserted at rdaddr = 300 gives rden = 0 and all outputs 0 the next cycle, and a following rd_start gives rd_underrun.
- Stats (with LINEBUF_PAGE_STATS_EN): 3 drops and 2 underruns give drop_cnt = 3 and underrun_cnt = 2; 300 drops give drop_cnt = 255.

Source files
------------

// File: rtl/linebuf_page_sched.sv
// Page scheduler for the paged dual-port line buffer: circular page hand-off to writer and reader,
// read address generation and line repeat. Define LINEBUF_PAGE_STATS_EN for drop/underrun counters.
module linebuf_page_sched #(
    parameter int unsigned num_of_pages = 4,
    parameter int unsigned pagesize     = 1024,
    parameter int unsigned rpt_max      = 4,
    localparam int unsigned PAGE_W = $clog2(num_of_pages),
    localparam int unsigned ADDR_W = $clog2(pagesize),
    localparam int unsigned LEN_W  = $clog2(pagesize + 1),
    localparam int unsigned RPT_W  = $clog2(rpt_max + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_start,
    input  logic              wr_done,
    input  logic [LEN_W-1:0]  wr_len,
    output logic              wr_busy,
    output logic [PAGE_W-1:0] wrpage,
    output logic              wr_drop,
`ifdef LINEBUF_PAGE_STATS_EN
    output logic [7:0]        drop_cnt,
    output logic [7:0]        underrun_cnt,
`endif
    input  logic              rd_start,
    input  logic [RPT_W-1:0]  rd_rpt,
    output logic              rden,
    output logic [PAGE_W-1:0] rdpage,
    output logic [ADDR_W-1:0] rdaddr,
    output logic              rd_line_done,
    output logic              rd_underrun
);

    localparam logic [LEN_W-1:0] PageSizeL = LEN_W'(pagesize);
    localparam logic [RPT_W-1:0] RptMaxL   = RPT_W'(rpt_max);

    typedef enum logic [1:0] {PgFree, PgWriting, PgReady, PgReading} pg_state_e;
    typedef enum logic       {WIdle, WAct} w_state_e;
    typedef enum logic [1:0] {RIdle, RRead, RHold} r_state_e;

    pg_state_e         pg_state_q [num_of_pages];
    pg_state_e         pg_state_d [num_of_pages];
    logic [LEN_W-1:0]  pg_len_q   [num_of_pages];
    logic [LEN_W-1:0]  pg_len_d   [num_of_pages];

    w_state_e          w_state_q, w_state_d;
    logic [PAGE_W-1:0] wp_q, wp_d;
    logic [PAGE_W-1:0] wrpage_q, wrpage_d;
    logic              wr_drop_q, wr_drop_d;

    r_state_e          r_state_q, r_state_d;
    logic [PAGE_W-1:0] rp_q, rp_d;
    logic [RPT_W-1:0]  rep_q, rep_d;
    logic              rden_q, rden_d;
    logic [PAGE_W-1:0] rdpage_q, rdpage_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic              rd_line_done_q, rd_line_done_d;
    logic              rd_underrun_q, rd_underrun_d;

    logic [LEN_W-1:0]  fin_len;
    logic [LEN_W-1:0]  cur_len;
    logic [RPT_W-1:0]  rep_load;
    logic [PAGE_W-1:0] rp_next;
    logic              try_claim;

    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
        return (p == PAGE_W'(num_of_pages - 1)) ? '0 : p + PAGE_W'(1);
    endfunction

    always_comb begin
        pg_state_d     = pg_state_q;
        pg_len_d       = pg_len_q;
        w_state_d      = w_state_q;
        wp_d           = wp_q;
        wrpage_d       = wrpage_q;
        wr_drop_d      = 1'b0;
        try_claim      = 1'b0;
        r_state_d      = r_state_q;
        rp_d           = rp_q;
        rep_d          = rep_q;
        rden_d         = 1'b0;
        rdpage_d       = rdpage_q;
        rdaddr_d       = '0;
        rd_line_done_d = 1'b0;
        rd_underrun_d  = 1'b0;

        fin_len  = (wr_len > PageSizeL) ? PageSizeL : wr_len;
        cur_len  = pg_len_q[rdpage_q];
        rp_next  = next_page(rp_q);
        rep_load = (rd_rpt == '0) ? RPT_W'(1) : ((rd_rpt > RptMaxL) ? RptMaxL : rd_rpt);

        // Writer: finish first, then a same-cycle start is judged against the advanced wp
        // using the page states registered before this edge.
        if (w_state_q == WAct) begin
            if (wr_done) begin
                w_state_d = WIdle;
                if (fin_len != '0) begin
                    pg_state_d[wrpage_q] = PgReady;
                    pg_len_d[wrpage_q]   = fin_len;
                    wp_d                 = next_page(wp_q);
                end else begin
                    pg_state_d[wrpage_q] = PgFree;
                end
                try_claim = wr_start;
            end
        end else begin
            try_claim = wr_start;
        end

        if (try_claim) begin
            if (pg_state_q[wp_d] == PgFree) begin
                pg_state_d[wp_d] = PgWriting;
                wrpage_d         = wp_d;
                w_state_d        = WAct;
            end else begin
                wr_drop_d = 1'b1;
            end
        end

        // Reader: touches only READY pages or the page it already holds.
        unique case (r_state_q)
            RIdle: begin
                if (rd_start) begin
                    if (pg_state_q[rp_q] == PgReady) begin
                        pg_state_d[rp_q] = PgReading;
                        rep_d            = rep_load;
                        rdpage_d         = rp_q;
                        rden_d           = 1'b1;
                        r_state_d        = RRead;
                    end else begin
                        rd_underrun_d = 1'b1;
                    end
                end
            end
            RRead: begin
                if (LEN_W'(rdaddr_q) == cur_len - LEN_W'(1)) begin
                    rd_line_done_d = 1'b1;
                    r_state_d      = RHold;
                    if (rep_q != '0) begin
                        rep_d = rep_q - RPT_W'(1);
                    end
                end else begin
                    rden_d   = 1'b1;
                    rdaddr_d = rdaddr_q + ADDR_W'(1);
                end
            end
            RHold: begin
                if (rd_start) begin
                    rden_d    = 1'b1;
                    r_state_d = RRead;
                    if (rep_q == '0) begin
                        if (pg_state_q[rp_next] == PgReady) begin
                            pg_state_d[rp_q]    = PgFree;
                            pg_state_d[rp_next] = PgReading;
                            rp_d                = rp_next;
                            rdpage_d            = rp_next;
                            rep_d               = rep_load;
                        end else begin
                            rd_underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(num_of_pages); i++) begin
                pg_state_q[i] <= PgFree;
                pg_len_q[i]   <= '0;
            end
            w_state_q      <= WIdle;
            wp_q           <= '0;
            wrpage_q       <= '0;
            wr_drop_q      <= 1'b0;
            r_state_q      <= RIdle;
            rp_q           <= '0;
            rep_q          <= '0;
            rden_q         <= 1'b0;
            rdpage_q       <= '0;
            rdaddr_q       <= '0;
            rd_line_done_q <= 1'b0;
            rd_underrun_q  <= 1'b0;
        end else begin
            pg_state_q     <= pg_state_d;
            pg_len_q       <= pg_len_d;
            w_state_q      <= w_state_d;
            wp_q           <= wp_d;
            wrpage_q       <= wrpage_d;
            wr_drop_q      <= wr_drop_d;
            r_state_q      <= r_state_d;
            rp_q           <= rp_d;
            rep_q          <= rep_d;
            rden_q         <= rden_d;
            rdpage_q       <= rdpage_d;
            rdaddr_q       <= rdaddr_d;
            rd_line_done_q <= rd_line_done_d;
            rd_underrun_q  <= rd_underrun_d;
        end
    end

    assign wr_busy      = (w_state_q == WAct);
    assign wrpage       = wrpage_q;
    assign wr_drop      = wr_drop_q;
    assign rden         = rden_q;
    assign rdpage       = rdpage_q;
    assign rdaddr       = rdaddr_q;
    assign rd_line_done = rd_line_done_q;
    assign rd_underrun  = rd_underrun_q;

`ifdef LINEBUF_PAGE_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic [7:0] underrun_cnt_q, underrun_cnt_d;

    always_comb begin
        drop_cnt_d     = drop_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        if (wr_drop_d && drop_cnt_q != 8'hff) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (rd_underrun_d && underrun_cnt_q != 8'hff) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt_q     <= '0;
            underrun_cnt_q <= '0;
        end else begin
            drop_cnt_q     <= drop_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign drop_cnt     = drop_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_linebuf_page_sched.sv
// Directed bench for linebuf_page_sched (default parameters: 4 pages, 1024 words, rpt_max 4).
module tb_linebuf_page_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wr_start, wr_done;
    logic [10:0] wr_len;
    logic        wr_busy, wr_drop;
    logic [1:0]  wrpage;
    logic        rd_start;
    logic [2:0]  rd_rpt;
    logic        rden, rd_line_done, rd_underrun;
    logic [1:0]  rdpage;
    logic [9:0]  rdaddr;
`ifdef LINEBUF_PAGE_STATS_EN
    logic [7:0]  drop_cnt, underrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    linebuf_page_sched dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_start     (wr_start),
        .wr_done      (wr_done),
        .wr_len       (wr_len),
        .wr_busy      (wr_busy),
        .wrpage       (wrpage),
        .wr_drop      (wr_drop),
`ifdef LINEBUF_PAGE_STATS_EN
        .drop_cnt     (drop_cnt),
        .underrun_cnt (underrun_cnt),
`endif
        .rd_start     (rd_start),
        .rd_rpt       (rd_rpt),
        .rden         (rden),
        .rdpage       (rdpage),
        .rdaddr       (rdaddr),
        .rd_line_done (rd_line_done),
        .rd_underrun  (rd_underrun)
    );

    typedef struct {
        int wr_len;
        int rpt;
        int exp_len;
        int passes;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        wr_start = 1'b0; wr_done = 1'b0; wr_len = '0;
        rd_start = 1'b0; rd_rpt = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic write_line(input string name, input int len, input int exp_page);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check({name, " busy after start"}, int'(wr_busy), 1);
        check({name, " wrpage"}, int'(wrpage), exp_page);
        wr_len  = 11'(len);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        check({name, " busy after done"}, int'(wr_busy), 0);
    endtask

    // One rd_start followed by a full pass of exp_len words from exp_page.
    task automatic read_pass(input string name, input int rpt, input int exp_page,
                             input int exp_len, input int exp_underrun);
        int bad;
        bad = 0;
        rd_rpt   = 3'(rpt);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check({name, " underrun"}, int'(rd_underrun), exp_underrun);
        for (int i = 0; i < exp_len; i++) begin
            if (rden !== 1'b1 || int'(rdaddr) != i || int'(rdpage) != exp_page
                || rd_line_done !== 1'b0) begin
                bad++;
            end
            tick();
        end
        check({name, " stream bad cycles"}, bad, 0);
        check({name, " rden low after pass"}, int'(rden), 0);
        check({name, " line_done"}, int'(rd_line_done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{640,  2, 640,  2};
        vecs[1] = '{2000, 1, 1024, 1};
        vecs[2] = '{1,    0, 1,    1};
        vecs[3] = '{10,   7, 10,   4};
        vecs[4] = '{100,  3, 100,  3};
        vecs[5] = '{1024, 4, 1024, 4};

        // Reset state
        do_reset();
        check("rst wr_busy", int'(wr_busy), 0);
        check("rst wrpage", int'(wrpage), 0);
        check("rst wr_drop", int'(wr_drop), 0);
        check("rst rden", int'(rden), 0);
        check("rst rdpage", int'(rdpage), 0);
        check("rst rdaddr", int'(rdaddr), 0);
        check("rst line_done", int'(rd_line_done), 0);
        check("rst underrun", int'(rd_underrun), 0);

        // Table: line A to page 0, line B (5 words) to page 1; A must give exactly
        // 'passes' passes of 'exp_len' words before B is taken.
        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset();
            write_line({tag, " lineA"}, vecs[v].wr_len, 0);
            write_line({tag, " lineB"}, 5, 1);
            for (int p = 0; p < vecs[v].passes; p++) begin
                read_pass($sformatf("%s pass%0d", tag, p), vecs[v].rpt, 0, vecs[v].exp_len, 0);
            end
            read_pass({tag, " next"}, 1, 1, 5, 0);
        end

        // Basic repeat, then underrun re-reads page 0
        do_reset();
        write_line("basic", 640, 0);
        read_pass("basic p0", 2, 0, 640, 0);
        read_pass("basic p1", 2, 0, 640, 0);
        read_pass("basic underrun reread", 2, 0, 640, 1);

        // Overflow
        do_reset();
        for (int i = 0; i < 4; i++) write_line($sformatf("ovf w%0d", i), 100, i);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check("ovf wr_drop", int'(wr_drop), 1);
        check("ovf busy stays 0", int'(wr_busy), 0);
        tick();
        check("ovf wr_drop one cycle", int'(wr_drop), 0);
        read_pass("ovf r0", 1, 0, 100, 0);
        read_pass("ovf r1", 1, 1, 100, 0);
        write_line("ovf reuse", 4, 0);

        // Zero length leaves page free and wp unchanged
        do_reset();
        write_line("len0", 0, 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("len0 underrun", int'(rd_underrun), 1);
        check("len0 no rden", int'(rden), 0);
        write_line("len0 retry", 5, 0);
        read_pass("len0 read", 1, 0, 5, 0);

        // Simultaneous done+start, abort restart, ignored done in idle
        do_reset();
        wr_start = 1'b1;
        tick();
        check("sim first page", int'(wrpage), 0);
        wr_len  = 11'd8;
        wr_done = 1'b1;
        tick();
        wr_done  = 1'b0;
        wr_start = 1'b0;
        check("sim wrpage advanced", int'(wrpage), 1);
        check("sim busy held", int'(wr_busy), 1);
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check("abort same page", int'(wrpage), 1);
        check("abort busy", int'(wr_busy), 1);
        wr_len  = 11'd3;
        wr_done = 1'b1;
        tick();
        check("sim done busy", int'(wr_busy), 0);
        wr_len = 11'd9;
        tick();
        wr_done = 1'b0;
        check("idle done ignored", int'(wr_busy), 0);
        read_pass("sim r0", 1, 0, 8, 0);
        read_pass("sim r1", 1, 1, 3, 0);
        read_pass("sim r1 underrun", 1, 1, 3, 1);

        // Reset mid-line
        do_reset();
        write_line("midrst", 640, 0);
        rd_rpt   = 3'd1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 1000 && !(rden === 1'b1 && rdaddr == 10'd300); i++) tick();
        check("midrst reached addr 300", int'(rdaddr), 300);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst rden", int'(rden), 0);
        check("midrst rdaddr", int'(rdaddr), 0);
        check("midrst rdpage", int'(rdpage), 0);
        check("midrst line_done", int'(rd_line_done), 0);
        check("midrst wr_busy", int'(wr_busy), 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("midrst underrun after", int'(rd_underrun), 1);
        check("midrst no rden after", int'(rden), 0);

`ifdef LINEBUF_PAGE_STATS_EN
        do_reset();
        for (int i = 0; i < 2; i++) begin
            rd_start = 1'b1;
            tick();
            rd_start = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) write_line($sformatf("st w%0d", i), 1, i);
        for (int i = 0; i < 3; i++) begin
            wr_start = 1'b1;
            tick();
            wr_start = 1'b0;
            tick();
        end
        check("stats drop_cnt 3", int'(drop_cnt), 3);
        check("stats underrun_cnt 2", int'(underrun_cnt), 2);
        wr_start = 1'b1;
        for (int i = 0; i < 297; i++) tick();
        wr_start = 1'b0;
        tick();
        check("stats drop_cnt sat", int'(drop_cnt), 255);
        do_reset();
        check("stats drop_cnt clear", int'(drop_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
